// File: rtl/uart_pkg.sv
// Shared UART constants: data width and default receive FIFO depth.
package uart_pkg;

    localparam int UART_DATA_W         = 8;
    localparam int UART_FIFO_DEPTH_DEF = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the UART receive FIFO: synchronous write, registered read.
// The array itself is never reset; only the read-data register is.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH_DEF,
    parameter int WIDTH = UART_DATA_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Wr_En,
    input  logic [AW-1:0]    i_Wr_Addr,
    input  logic [WIDTH-1:0] i_Wr_Data,
    input  logic             i_Rd_En,
    input  logic [AW-1:0]    i_Rd_Addr,
    output logic [WIDTH-1:0] o_Rd_Data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_Clock) begin
        if (i_Wr_En) begin
            mem[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    // Read register holds its value between reads so the consumer sees a stable byte.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            o_Rd_Data <= '0;
        end else if (i_Rd_En) begin
            o_Rd_Data <= mem[i_Rd_Addr];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: pointers, occupancy count, registered flags and sticky overflow
// around a uart_fifo_mem storage block.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH_DEF,
    parameter int WIDTH = UART_DATA_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_RX_DV,
    input  logic [WIDTH-1:0] i_RX_Byte,
    input  logic             i_Rd_En,
    input  logic             i_Clr_Overflow,
    output logic [WIDTH-1:0] o_Rd_Byte,
    output logic             o_Rd_DV,
    output logic             o_Empty,
    output logic             o_Full,
    output logic [CW-1:0]    o_Count,
    output logic             o_Overflow
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_next;
    logic          wr_acc;
    logic          rd_acc;

    // Acceptance uses the registered flags, so a write into an empty FIFO cannot be read the same cycle.
    assign wr_acc = i_RX_DV && !o_Full;
    assign rd_acc = i_Rd_En && !o_Empty;

    always_comb begin
        count_next = o_Count;
        if (wr_acc && !rd_acc) begin
            count_next = o_Count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = o_Count - CW'(1);
        end
    end

    // DEPTH is a power of two, so pointer rollover gives the modulo wrap for free.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_Count    <= '0;
            o_Empty    <= 1'b1;
            o_Full     <= 1'b0;
            o_Rd_DV    <= 1'b0;
            o_Overflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            o_Count <= count_next;
            o_Empty <= (count_next == '0);
            o_Full  <= (count_next == CW'(DEPTH));
            o_Rd_DV <= rd_acc;
            if (i_RX_DV && o_Full) begin
                o_Overflow <= 1'b1;
            end else if (i_Clr_Overflow) begin
                o_Overflow <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .i_Wr_En   (wr_acc),
        .i_Wr_Addr (wr_ptr),
        .i_Wr_Data (i_RX_Byte),
        .i_Rd_En   (rd_acc),
        .i_Rd_Addr (rd_ptr),
        .o_Rd_Data (o_Rd_Byte)
    );

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, meaning number of byte entries (power of two, 4..256).
REQ-002 SHALL provide parameter WIDTH, default 8, meaning bits per entry.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: i_Clock  input  1  rising-edge clock; i_Reset  input  1  asynchronous active-high reset.
REQ-004 SHALL have i_RX_DV  input  1  write strobe, one-cycle pulse from the UART receiver.
REQ-005 SHALL have i_RX_Byte  input  WIDTH  byte to store, valid when i_RX_DV=1.
REQ-006 SHALL have i_Rd_En  input  1  read request from consumer.
REQ-007 SHALL have o_Rd_Byte  output  WIDTH  oldest byte, valid when o_Rd_DV=1.
REQ-008 SHALL have o_Rd_DV  output  1  one-cycle pulse marking o_Rd_Byte valid.
REQ-009 SHALL have o_Empty  output  1, o_Full  output  1  occupancy flags.
REQ-010 SHALL have o_Count  output  log2(DEPTH)+1  current occupancy.
REQ-011 SHALL have o_Overflow  output  1  sticky dropped-byte flag; i_Clr_Overflow  input  1  clears it.

Function
REQ-012 Write accepted when i_RX_DV=1 and o_Full=0 (registered flag); byte stored at write pointer, pointer increments modulo DEPTH.
REQ-013 i_RX_DV=1 while o_Full=1 SHALL drop the byte, leave storage/pointers unchanged, set o_Overflow next cycle, even if a read occurs the same cycle.
REQ-014 Read accepted when i_Rd_En=1 and o_Empty=0; read pointer increments modulo DEPTH; o_Rd_Byte updated and o_Rd_DV=1 exactly one cycle later (latency 1).
REQ-015 i_Rd_En=1 while o_Empty=1 SHALL be ignored: no pointer change, o_Rd_DV=0, o_Rd_Byte holds.
REQ-016 o_Rd_Byte SHALL hold its last value between reads; o_Rd_DV SHALL be 0 in every cycle not following an accepted read.
REQ-017 Accepted write and accepted read in the same cycle: both execute, o_Count unchanged.
REQ-018 Write into empty FIFO with simultaneous i_Rd_En: write accepted, read ignored; byte readable from the next cycle.
REQ-019 o_Count SHALL equal accepted writes minus accepted reads since reset, range 0..DEPTH; o_Empty=(o_Count==0), o_Full=(o_Count==DEPTH), all registered.
REQ-020 Pointers SHALL wrap DEPTH-1 -> 0 with no loss or duplication.
REQ-021 i_Clr_Overflow=1 clears o_Overflow next cycle; simultaneous overflow event and clear SHALL leave o_Overflow=1 (set wins).
REQ-022 Stored data order SHALL be strictly first-in first-out.

Reset
REQ-023 i_Reset=1 SHALL asynchronously force: pointers 0, o_Count=0, o_Empty=1, o_Full=0, o_Overflow=0, o_Rd_DV=0, o_Rd_Byte=0.
REQ-024 Reset mid-operation SHALL discard all stored bytes; storage array need not be cleared.
REQ-025 Strobes during reset SHALL be ignored; first accepted write is on the first rising edge after i_Reset deasserts.

Structure
REQ-026 Shared package uart_pkg SHALL hold UART_DATA_W=8 and UART_FIFO_DEPTH_DEF=16, used as parameter defaults.
REQ-027 Storage SHALL be one sub-module uart_fifo_mem (DEPTH x WIDTH array, synchronous write, registered read, no reset on the array); pointers, count, flags and overflow logic stay in uart_rx_fifo.

Verification
REQ-028 Write 0x11,0x22,0x33 then 3 reads -> o_Rd_DV pulses 1 cycle after each i_Rd_En with 0x11,0x22,0x33; o_Empty=1, o_Count=0 at end.
REQ-029 Write 17 bytes 0x00..0x10 (DEPTH=16), no reads -> o_Full=1 after 16th, 0x10 dropped, o_Overflow=1; 16 reads return 0x00..0x0F.
REQ-030 FIFO at count 5, simultaneous i_RX_DV=1 (0xA5) and i_Rd_En=1 -> o_Count stays 5, oldest byte output, 0xA5 is last out.
REQ-031 Empty FIFO, i_Rd_En=1 alone -> o_Rd_DV=0, o_Count=0; then i_RX_DV=1 with i_Rd_En=1 (0x5A) -> o_Count=1, o_Rd_DV=0; next read returns 0x5A.
REQ-032 40 writes interleaved with reads (pointer wrap twice) -> all 40 bytes returned in order, no o_Overflow.
REQ-033 Assert i_Reset at count 7 with o_Overflow=1 -> immediate o_Count=0, o_Empty=1, o_Overflow=0, o_Rd_DV=0; post-reset write/read of 0xC3 returns 0xC3.
